vadd_stream_join_adder: RTL and testbench
=========================================

// Module: vadd_stream_join_adder
// PURPOSE
//  Consumer stage that joins the A read stream (rd_t* from the A reader) with the B read stream.
//  Per beat it adds the two streams lane-wise and emits the sum stream to the B writer.
//  Runs one vector per ap_start; pulses ap_done once the last sum beat has left the block.
// PARAMETERS
//  C_DATA_WIDTH       512  stream width in bits; must be a multiple of C_ADDER_BIT_WIDTH
//  C_ADDER_BIT_WIDTH  32   lane width; lanes = C_DATA_WIDTH/C_ADDER_BIT_WIDTH
//  C_FIFO_DEPTH       4    output FIFO entries; power of 2, >=4
// PORTS
//  aclk              in   1              single clock, all logic rising-edge
//  areset            in   1              asynchronous, active-high reset
//  ap_start          in   1              one-cycle start pulse
//  ap_done           out  1              one-cycle done pulse
//  s_a_tvalid/tready in/out 1            A stream handshake
//  s_a_tdata         in   C_DATA_WIDTH   A data
//  s_a_tlast         in   1              A last beat
//  s_b_tvalid/tready in/out 1            B stream handshake
//  s_b_tdata         in   C_DATA_WIDTH   B data
//  s_b_tlast         in   1              B last beat
//  m_tvalid          out  1              sum stream valid
//  m_tready          in   1              sum stream ready
//  m_tdata           out  C_DATA_WIDTH   sum data
//  m_tlast           out  1              sum last beat
//  beat_count        out  32             beats accepted this run
//  err_last_mismatch out  1              sticky: A/B tlast disagreed
// BEHAVIOUR
//  Reset (async assert, sync release): FSM=IDLE; FIFO and stage emptied.
//   All outputs 0, including m_tvalid, both treadys, ap_done, beat_count and err.
//   Reset mid-run drops all in-flight beats; no ap_done is issued.
//  FSM IDLE -> RUN on ap_start: clears beat_count and err_last_mismatch.
//   ap_start while in RUN/FLUSH/DONE is ignored.
//  RUN: fire = s_a_tvalid & s_b_tvalid & (fifo_count + stage_valid < C_FIFO_DEPTH).
//   s_a_tready = s_b_tready = RUN & fire; both streams always pop together, never one alone.
//   tready never asserted outside RUN.
//  Fire at cycle N: stage register holds sum at N+1 and is written to FIFO at N+2.
//   With FIFO empty, the beat is visible on m_* at N+2; the FIFO has a registered output.
//   Sustained throughput is 1 beat/cycle while m_tready=1.
//  Lane i sum = (a[i]+b[i]) mod 2^C_ADDER_BIT_WIDTH; no carry crosses lanes.
//  m_tlast = a_tlast | b_tlast.
//  If a_tlast != b_tlast on a fired beat, set err_last_mismatch (held until next ap_start).
//  beat_count +1 per fire; saturates at 32'hFFFF_FFFF.
//  A fire with a_tlast|b_tlast moves RUN -> FLUSH; no further beats are accepted.
//  FLUSH -> DONE when stage empty, FIFO empty, and no m_* handshake pending.
//   DONE asserts ap_done for exactly 1 cycle, then -> IDLE.
//  m_tvalid/m_tdata/m_tlast are held stable while m_tvalid & ~m_tready (AXIS rule).
//  FIFO full with m_tready=0: treadys drop; no overflow, no loss.
//  Simultaneous FIFO push+pop at full/empty boundaries: count unchanged.
// STRUCTURE
//  Package vadd_pkg:
//   - state_t enum {IDLE,RUN,FLUSH,DONE}
//   - localparam LP_LANES
//   - function lane_add(a,b)
//  Sub-module vadd_axis_fifo (depth, width = C_DATA_WIDTH+1), registered output, full/empty/count.
//  Top holds the FSM, join/credit logic, lane adders, stage register, counter and error flag.
// TESTING
//  T1 4 beats, a lanes=i, b lanes=100+i, m_tready=1:
//     -> sums 100+2i, first m_tvalid 2 cycles after first fire, 1 beat/cycle
//     -> tlast on beat 4, ap_done 1 cycle, beat_count=4
//  T2 lanes a=32'hFFFF_FFFF, b=32'h2
//     -> every lane 32'h1; neighbouring lanes unaffected
//  T3 16 beats, m_tready low for 10 cycles mid-run
//     -> treadys drop after 4 occupancy; no beat lost/duplicated; m_* stable while stalled
//  T4 a_tlast on beat 3, b_tlast on beat 5
//     -> run ends at beat 3, err_last_mismatch=1, beat_count=3; next ap_start clears both
//  T5 B stream valid 2 cycles late per beat
//     -> A never popped alone; tready only when both valid
//  T6 areset pulsed with 2 beats in flight
//     -> m_tvalid=0 immediately, no ap_done; fresh ap_start runs 2 beats cleanly

Source files
------------

// File: rtl/vadd_pkg.sv
// Shared types and lane arithmetic for the vector-add join/adder stage.
package vadd_pkg;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   localparam int LP_DATA_WIDTH      = 512;
   localparam int LP_ADDER_BIT_WIDTH = 32;
   localparam int LP_LANES           = LP_DATA_WIDTH / LP_ADDER_BIT_WIDTH;

   // Independent modular adds per lane; carries never cross a lane boundary.
   function automatic logic [LP_DATA_WIDTH-1:0] lane_add(
      input logic [LP_DATA_WIDTH-1:0] a,
      input logic [LP_DATA_WIDTH-1:0] b
   );
      logic [LP_DATA_WIDTH-1:0] s;
      s = '0;
      for (int i = 0; i < LP_LANES; i++) begin
         s[i*LP_ADDER_BIT_WIDTH +: LP_ADDER_BIT_WIDTH] =
            a[i*LP_ADDER_BIT_WIDTH +: LP_ADDER_BIT_WIDTH] +
            b[i*LP_ADDER_BIT_WIDTH +: LP_ADDER_BIT_WIDTH];
      end
      return s;
   endfunction

endpackage

// File: rtl/vadd_axis_fifo.sv
// Flop-based output FIFO; the head entry is driven straight from storage
// so it stays stable until popped.
module vadd_axis_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 513
) (
   input  logic                       aclk,
   input  logic                       areset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign do_pop   = pop & ~empty;
   // A pop frees the slot being overwritten, so push+pop at full is legal.
   assign do_push  = push & (~full | pop);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/vadd_stream_join_adder.sv
// Joins the A and B read streams, adds them lane-wise and streams the sums
// to the writer through a stage register and a small output FIFO.
//
//  state | meaning
//  IDLE  | waiting for ap_start
//  RUN   | accepting joined beats until a tlast fires
//  FLUSH | draining stage register and FIFO
//  DONE  | ap_done high for this single cycle
module vadd_stream_join_adder
   import vadd_pkg::*;
#(
   parameter int C_DATA_WIDTH      = LP_DATA_WIDTH,
   parameter int C_ADDER_BIT_WIDTH = LP_ADDER_BIT_WIDTH,
   parameter int C_FIFO_DEPTH      = 4
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic                    ap_start,
   output logic                    ap_done,
   input  logic                    s_a_tvalid,
   output logic                    s_a_tready,
   input  logic [C_DATA_WIDTH-1:0] s_a_tdata,
   input  logic                    s_a_tlast,
   input  logic                    s_b_tvalid,
   output logic                    s_b_tready,
   input  logic [C_DATA_WIDTH-1:0] s_b_tdata,
   input  logic                    s_b_tlast,
   output logic                    m_tvalid,
   input  logic                    m_tready,
   output logic [C_DATA_WIDTH-1:0] m_tdata,
   output logic                    m_tlast,
   output logic [31:0]             beat_count,
   output logic                    err_last_mismatch
);

   localparam int CW    = $clog2(C_FIFO_DEPTH) + 1;
   localparam int LANES = C_DATA_WIDTH / C_ADDER_BIT_WIDTH;

   state_t                  state;
   logic                    stage_valid;
   logic                    stage_last;
   logic [C_DATA_WIDTH-1:0] stage_data;
   logic [C_DATA_WIDTH-1:0] sum;
   logic [C_DATA_WIDTH:0]   fifo_dout;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic [CW-1:0]           fifo_count;
   logic [CW:0]             occupancy;
   logic                    fire;
   logic                    any_last;

   // The stage register holds a credit too, so a fired beat always finds room.
   assign occupancy  = {1'b0, fifo_count} + {{CW{1'b0}}, stage_valid};
   assign fire       = (state == RUN) & s_a_tvalid & s_b_tvalid & ~fifo_full &
                       (occupancy < (CW+1)'(C_FIFO_DEPTH));
   assign s_a_tready = fire;
   assign s_b_tready = fire;
   assign any_last   = s_a_tlast | s_b_tlast;

   generate
      if (C_DATA_WIDTH == LP_DATA_WIDTH && C_ADDER_BIT_WIDTH == LP_ADDER_BIT_WIDTH) begin : g_pkg_add
         assign sum = lane_add(s_a_tdata, s_b_tdata);
      end else begin : g_generic_add
         for (genvar i = 0; i < LANES; i++) begin : g_lane
            assign sum[i*C_ADDER_BIT_WIDTH +: C_ADDER_BIT_WIDTH] =
               s_a_tdata[i*C_ADDER_BIT_WIDTH +: C_ADDER_BIT_WIDTH] +
               s_b_tdata[i*C_ADDER_BIT_WIDTH +: C_ADDER_BIT_WIDTH];
         end
      end
   endgenerate

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         stage_valid <= 1'b0;
         stage_last  <= 1'b0;
         stage_data  <= '0;
      end else begin
         stage_valid <= fire;
         if (fire) begin
            stage_data <= sum;
            stage_last <= any_last;
         end
      end
   end

   vadd_axis_fifo #(
      .DEPTH (C_FIFO_DEPTH),
      .WIDTH (C_DATA_WIDTH + 1)
   ) u_fifo (
      .aclk      (aclk),
      .areset    (areset),
      .push      (stage_valid),
      .push_data ({stage_last, stage_data}),
      .pop       (m_tvalid & m_tready),
      .pop_data  (fifo_dout),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign m_tvalid = ~fifo_empty;
   assign m_tlast  = fifo_dout[C_DATA_WIDTH];
   assign m_tdata  = fifo_dout[C_DATA_WIDTH-1:0];

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state             <= IDLE;
         ap_done           <= 1'b0;
         beat_count        <= '0;
         err_last_mismatch <= 1'b0;
      end else begin
         ap_done <= 1'b0;
         case (state)
            IDLE: begin
               if (ap_start) begin
                  state             <= RUN;
                  beat_count        <= '0;
                  err_last_mismatch <= 1'b0;
               end
            end
            RUN: begin
               if (fire) begin
                  if (beat_count != 32'hFFFF_FFFF) begin
                     beat_count <= beat_count + 32'd1;
                  end
                  if (s_a_tlast != s_b_tlast) begin
                     err_last_mismatch <= 1'b1;
                  end
                  if (any_last) begin
                     state <= FLUSH;
                  end
               end
            end
            FLUSH: begin
               // An empty FIFO means m_tvalid is low, so no handshake is pending.
               if (!stage_valid && fifo_empty) begin
                  state   <= DONE;
                  ap_done <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vadd_stream_join_adder.sv
// Directed bench for vadd_stream_join_adder with a queue-based reference
// model of the joined, lane-wise summed stream.
module tb_vadd_stream_join_adder;

   localparam int DW = 512;
   localparam int LW = 32;
   localparam int NL = DW / LW;

   logic          aclk = 1'b0;
   logic          areset = 1'b1;
   logic          ap_start = 1'b0;
   logic          ap_done;
   logic          s_a_tvalid = 1'b0;
   logic          s_a_tready;
   logic [DW-1:0] s_a_tdata = '0;
   logic          s_a_tlast = 1'b0;
   logic          s_b_tvalid = 1'b0;
   logic          s_b_tready;
   logic [DW-1:0] s_b_tdata = '0;
   logic          s_b_tlast = 1'b0;
   logic          m_tvalid;
   logic          m_tready = 1'b1;
   logic [DW-1:0] m_tdata;
   logic          m_tlast;
   logic [31:0]   beat_count;
   logic          err_last_mismatch;

   vadd_stream_join_adder dut (
      .aclk              (aclk),
      .areset            (areset),
      .ap_start          (ap_start),
      .ap_done           (ap_done),
      .s_a_tvalid        (s_a_tvalid),
      .s_a_tready        (s_a_tready),
      .s_a_tdata         (s_a_tdata),
      .s_a_tlast         (s_a_tlast),
      .s_b_tvalid        (s_b_tvalid),
      .s_b_tready        (s_b_tready),
      .s_b_tdata         (s_b_tdata),
      .s_b_tlast         (s_b_tlast),
      .m_tvalid          (m_tvalid),
      .m_tready          (m_tready),
      .m_tdata           (m_tdata),
      .m_tlast           (m_tlast),
      .beat_count        (beat_count),
      .err_last_mismatch (err_last_mismatch)
   );

   always #5 aclk = ~aclk;

   int cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   logic [DW:0]   exp_q[$];
   logic [DW-1:0] av[];
   logic [DW-1:0] bv[];
   bit            al[];
   bit            bl[];
   int            b_delay = 0;

   int            n_fire = 0;
   int            n_pop = 0;
   int            done_cnt = 0;
   int            first_fire_cyc = -1;
   int            first_valid_cyc = -1;
   int            first_pop_cyc = -1;
   int            last_pop_cyc = -1;
   logic [DW:0]   first_out = '0;

   task automatic check(input bit ok, input string name, input logic [DW:0] act, input logic [DW:0] req);
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic eq(input string name, input logic [DW:0] act, input logic [DW:0] req);
      check(act === req, name, act, req);
   endtask

   function automatic logic [DW-1:0] model_sum(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [DW-1:0] r;
      longint        s;
      r = '0;
      for (int i = 0; i < NL; i++) begin
         s = longint'(a[i*LW +: LW]) + longint'(b[i*LW +: LW]);
         r[i*LW +: LW] = s[LW-1:0];
      end
      return r;
   endfunction

   task automatic monitor();
      logic [DW:0] prev_out;
      bit          prev_stall;
      bit          prev_done;
      prev_out   = '0;
      prev_stall = 1'b0;
      prev_done  = 1'b0;
      forever begin
         @(negedge aclk);
         if (areset) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
            continue;
         end
         if (s_a_tvalid | s_b_tvalid | s_a_tready | s_b_tready) begin
            eq("tready_pair", s_a_tready, s_b_tready);
            if (s_a_tready) eq("tready_needs_both_valid", s_a_tvalid & s_b_tvalid, 1);
         end
         if (prev_stall) begin
            eq("axis_hold_valid", m_tvalid, 1);
            eq("axis_hold_data", {m_tlast, m_tdata}, prev_out);
         end
         if (m_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (m_tvalid & m_tready) begin
            if (exp_q.size() == 0) check(1'b0, "unexpected_beat", {m_tlast, m_tdata}, 0);
            else eq("m_beat", {m_tlast, m_tdata}, exp_q.pop_front());
            if (first_pop_cyc < 0) begin
               first_pop_cyc = cyc;
               first_out     = {m_tlast, m_tdata};
            end
            last_pop_cyc = cyc;
            n_pop++;
         end
         if (s_a_tready & s_b_tready & s_a_tvalid & s_b_tvalid) begin
            exp_q.push_back({s_a_tlast | s_b_tlast, model_sum(s_a_tdata, s_b_tdata)});
            if (first_fire_cyc < 0) first_fire_cyc = cyc;
            n_fire++;
         end
         if (ap_done) begin
            done_cnt++;
            if (prev_done) check(1'b0, "ap_done_width", 2, 1);
            eq("done_after_drain", m_tvalid, 0);
         end
         prev_stall = m_tvalid & ~m_tready;
         prev_out   = {m_tlast, m_tdata};
         prev_done  = ap_done;
      end
   endtask

   task automatic build(input int n, input int pat, input int alast, input int blast);
      av = new[n];
      bv = new[n];
      al = new[n];
      bl = new[n];
      for (int k = 0; k < n; k++) begin
         for (int i = 0; i < NL; i++) begin
            case (pat)
               0: begin
                  av[k][i*LW +: LW] = 32'(i + k * 65536);
                  bv[k][i*LW +: LW] = 32'(100 + i + k * 256);
               end
               1: begin
                  av[k][i*LW +: LW] = 32'hFFFF_FFFF;
                  bv[k][i*LW +: LW] = 32'h2;
               end
               default: begin
                  av[k][i*LW +: LW] = $urandom;
                  bv[k][i*LW +: LW] = $urandom;
               end
            endcase
         end
         al[k] = (k + 1 == alast);
         bl[k] = (k + 1 == blast);
      end
   endtask

   task automatic drive_a();
      for (int k = 0; k < av.size(); k++) begin
         int t;
         bit got;
         s_a_tvalid = 1'b1;
         s_a_tdata  = av[k];
         s_a_tlast  = al[k];
         t = 0;
         got = 1'b0;
         while (!got && t < 400) begin
            @(negedge aclk);
            if (s_a_tready) got = 1'b1;
            t++;
         end
         if (!got) begin
            check(1'b0, "a_handshake_timeout", k, av.size());
            break;
         end
         @(posedge aclk);
         #1;
      end
      s_a_tvalid = 1'b0;
      s_a_tlast  = 1'b0;
   endtask

   task automatic drive_b();
      for (int k = 0; k < bv.size(); k++) begin
         int t;
         bit got;
         if (b_delay > 0) begin
            s_b_tvalid = 1'b0;
            repeat (b_delay) @(posedge aclk);
            #1;
         end
         s_b_tvalid = 1'b1;
         s_b_tdata  = bv[k];
         s_b_tlast  = bl[k];
         t = 0;
         got = 1'b0;
         while (!got && t < 400) begin
            @(negedge aclk);
            if (s_b_tready) got = 1'b1;
            t++;
         end
         if (!got) begin
            check(1'b0, "b_handshake_timeout", k, bv.size());
            break;
         end
         @(posedge aclk);
         #1;
      end
      s_b_tvalid = 1'b0;
      s_b_tlast  = 1'b0;
   endtask

   task automatic run_vec();
      fork
         drive_a();
         drive_b();
      join
   endtask

   task automatic start();
      ap_start = 1'b1;
      @(posedge aclk);
      #1;
      ap_start = 1'b0;
   endtask

   task automatic clear_marks();
      first_fire_cyc  = -1;
      first_valid_cyc = -1;
      first_pop_cyc   = -1;
      last_pop_cyc    = -1;
   endtask

   task automatic wait_done(input string name);
      int base;
      int t;
      base = done_cnt;
      t = 0;
      while (done_cnt == base && t < 300) begin
         @(negedge aclk);
         t++;
      end
      check(done_cnt != base, {name, "_done_timeout"}, done_cnt, base + 1);
      repeat (3) @(posedge aclk);
      #1;
      eq({name, "_done_once"}, done_cnt, base + 1);
      eq({name, "_model_drained"}, exp_q.size(), 0);
   endtask

   task automatic main_seq();
      int pops0;
      int fires0;
      logic [DW-1:0] ones_lanes;
      int base;

      // Reset state, with valids driven to make tready checks meaningful
      s_a_tvalid = 1'b1;
      s_b_tvalid = 1'b1;
      repeat (3) @(posedge aclk);
      #1;
      eq("rst_m_tvalid", m_tvalid, 0);
      eq("rst_m_tdata", m_tdata, 0);
      eq("rst_m_tlast", m_tlast, 0);
      eq("rst_ap_done", ap_done, 0);
      eq("rst_a_tready", s_a_tready, 0);
      eq("rst_b_tready", s_b_tready, 0);
      eq("rst_beat_count", beat_count, 0);
      eq("rst_err", err_last_mismatch, 0);
      s_a_tvalid = 1'b0;
      s_b_tvalid = 1'b0;
      areset = 1'b0;
      repeat (2) @(posedge aclk);
      #1;

      // T1: 4 beats, lane sums 100+2i, latency 2, 1 beat/cycle, stray ap_start
      clear_marks();
      pops0 = n_pop;
      build(4, 0, 4, 4);
      b_delay = 0;
      fork
         begin
            start();
            repeat (2) @(posedge aclk);
            #1;
            ap_start = 1'b1;
            @(posedge aclk);
            #1;
            ap_start = 1'b0;
         end
         run_vec();
      join
      wait_done("t1");
      eq("t1_latency", first_valid_cyc - first_fire_cyc, 2);
      eq("t1_throughput", last_pop_cyc - first_pop_cyc, 3);
      eq("t1_lane0", first_out[31:0], 100);
      eq("t1_lane15", first_out[DW-1 -: LW], 130);
      eq("t1_first_not_last", first_out[DW], 0);
      eq("t1_beats_out", n_pop - pops0, 4);
      eq("t1_beat_count", beat_count, 4);
      eq("t1_err", err_last_mismatch, 0);

      // T2: per-lane wrap with no carry into neighbours
      clear_marks();
      build(2, 1, 2, 2);
      start();
      run_vec();
      wait_done("t2");
      for (int i = 0; i < NL; i++) ones_lanes[i*LW +: LW] = 32'h1;
      eq("t2_wrap_lanes", first_out[DW-1:0], ones_lanes);
      eq("t2_beat_count", beat_count, 2);

      // T3: 16 beats with a 10-cycle sink stall
      clear_marks();
      pops0 = n_pop;
      build(16, 2, 16, 16);
      start();
      fork
         run_vec();
         begin
            repeat (6) @(posedge aclk);
            #1;
            m_tready = 1'b0;
            fires0 = n_fire;
            repeat (10) @(posedge aclk);
            @(negedge aclk);
            #1;
            eq("t3_stall_occupancy", (n_fire - fires0) + (fires0 - n_pop) + (n_pop - pops0) - (n_pop - pops0), 4);
            eq("t3_stall_tready", s_a_tready, 0);
            @(posedge aclk);
            #1;
            m_tready = 1'b1;
         end
      join
      wait_done("t3");
      eq("t3_beats_out", n_pop - pops0, 16);
      eq("t3_beat_count", beat_count, 16);

      // T4: tlast disagreement ends the run early and sets the sticky error
      clear_marks();
      build(3, 0, 3, 0);
      start();
      run_vec();
      wait_done("t4");
      eq("t4_beat_count", beat_count, 3);
      eq("t4_err", err_last_mismatch, 1);
      start();
      eq("t4_err_cleared", err_last_mismatch, 0);
      eq("t4_count_cleared", beat_count, 0);
      build(1, 0, 1, 1);
      run_vec();
      wait_done("t4b");
      eq("t4b_beat_count", beat_count, 1);
      eq("t4b_err", err_last_mismatch, 0);

      // T5: B arrives 2 cycles late on each beat
      clear_marks();
      pops0 = n_pop;
      build(4, 2, 4, 4);
      b_delay = 2;
      start();
      run_vec();
      b_delay = 0;
      wait_done("t5");
      eq("t5_beats_out", n_pop - pops0, 4);
      eq("t5_beat_count", beat_count, 4);

      // T6: reset with beats in flight, then a clean run
      m_tready = 1'b0;
      build(2, 2, 0, 0);
      start();
      run_vec();
      @(posedge aclk);
      #1;
      eq("t6_inflight", m_tvalid, 1);
      #1;
      areset = 1'b1;
      #1;
      eq("t6_rst_m_tvalid", m_tvalid, 0);
      eq("t6_rst_tready", s_a_tready, 0);
      eq("t6_rst_beat_count", beat_count, 0);
      @(posedge aclk);
      #1;
      areset = 1'b0;
      exp_q.delete();
      m_tready = 1'b1;
      base = done_cnt;
      repeat (10) @(posedge aclk);
      #1;
      eq("t6_no_done", done_cnt, base);
      eq("t6_idle_empty", m_tvalid, 0);
      clear_marks();
      pops0 = n_pop;
      build(2, 0, 2, 2);
      start();
      run_vec();
      wait_done("t6");
      eq("t6_beats_out", n_pop - pops0, 2);
      eq("t6_beat_count", beat_count, 2);
      eq("t6_err", err_last_mismatch, 0);
   endtask

   initial begin
      fork
         monitor();
         main_seq();
         begin
            #500000;
            $display("FAIL watchdog: simulation time limit reached");
            $fatal(1, "watchdog");
         end
      join_any
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
